// File: rtl/bram_debug_sequencer_if.sv
// Host command/stream channels and RV32Core debug-port signals for bram_debug_sequencer.
// slave = sequencer side; master = host link plus the two BRAM debug ports.
interface bram_debug_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic        cmd_sel;
    logic [11:0] cmd_base;
    logic [12:0] cmd_len;
    logic [31:0] cmd_cycles;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    logic [31:0] dbg_data_a2;
    logic [31:0] dbg_data_wd2;
    logic [3:0]  dbg_data_we2;
    logic [31:0] dbg_data_rd2;
    logic [31:0] dbg_inst_a2;
    logic [31:0] dbg_inst_wd2;
    logic [3:0]  dbg_inst_we2;
    logic [31:0] dbg_inst_rd2;

    logic        done;

    modport master (
        output cmd_valid, cmd_op, cmd_sel, cmd_base, cmd_len, cmd_cycles,
        input  cmd_ready,
        output in_valid, in_data,
        input  in_ready,
        input  out_valid, out_data, out_last,
        output out_ready,
        input  dbg_data_a2, dbg_data_wd2, dbg_data_we2,
        input  dbg_inst_a2, dbg_inst_wd2, dbg_inst_we2,
        output dbg_data_rd2, dbg_inst_rd2,
        input  done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_sel, cmd_base, cmd_len, cmd_cycles,
        output cmd_ready,
        input  in_valid, in_data,
        output in_ready,
        output out_valid, out_data, out_last,
        input  out_ready,
        output dbg_data_a2, dbg_data_wd2, dbg_data_we2,
        output dbg_inst_a2, dbg_inst_wd2, dbg_inst_we2,
        input  dbg_data_rd2, dbg_inst_rd2,
        output done
    );
endinterface

// File: rtl/bram_debug_sequencer.sv
// LOAD / RUN / DUMP sequencer driving the RV32Core BRAM debug ports and core reset.
// Optional LOAD_CHECKSUM_EN adds load_sum, the mod-2^32 sum of words accepted by the last LOAD.
module bram_debug_sequencer #(
    parameter int BRAMWORDS  = 4096,
    parameter int RST_CYCLES = 5
) (
    input  logic                         CPU_CLK,
    input  logic                         CPU_RST,
    bram_debug_sequencer_if.slave        bus,
    output logic                         core_rst
`ifdef LOAD_CHECKSUM_EN
    ,
    output logic [31:0]                  load_sum
`endif
);
    localparam int AW = $clog2(BRAMWORDS);

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_DUMP = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RST_PULSE, S_RUN, S_DUMP_RD, S_DUMP_WAIT, S_DUMP_OUT
    } state_t;

    state_t          state, state_nxt;
    logic            sel_r;
    logic [AW-1:0]   base_r;
    logic [12:0]     len_r;
    logic [31:0]     cycles_r;
    logic [12:0]     k;
    logic [31:0]     cnt;

    logic [12:0]     len_c;
    logic [AW-1:0]   idx_cur, idx_next;
    logic            k_last, in_fire, out_fire;

    function automatic logic [31:0] byte_addr(input logic [AW-1:0] idx);
        return {{(30-AW){1'b0}}, idx, 2'b00};
    endfunction

    assign len_c    = (bus.cmd_len > 13'(BRAMWORDS)) ? 13'(BRAMWORDS) : bus.cmd_len;
    assign idx_cur  = base_r + k[AW-1:0];
    assign idx_next = idx_cur + AW'(1);
    assign k_last   = (k == len_r - 13'd1);
    assign in_fire  = (state == S_LOAD) && bus.in_valid;
    assign out_fire = (state == S_DUMP_OUT) && bus.out_ready;

    always_ff @(posedge CPU_CLK) begin
        if (!CPU_RST) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.cmd_ready = (state == S_IDLE);
        bus.in_ready  = (state == S_LOAD);
        case (state)
            S_IDLE: if (bus.cmd_valid) begin
                case (bus.cmd_op)
                    OP_LOAD: if (len_c != '0) state_nxt = S_LOAD;
                    OP_RUN:  state_nxt = S_RST_PULSE;
                    OP_DUMP: if (len_c != '0) state_nxt = S_DUMP_RD;
                    default: state_nxt = S_IDLE;
                endcase
            end
            S_LOAD:      if (in_fire && k_last) state_nxt = S_IDLE;
            S_RST_PULSE: if (cnt == 32'(RST_CYCLES - 1)) state_nxt = S_RUN;
            S_RUN:       if (cnt <= 32'd1) state_nxt = S_IDLE;
            S_DUMP_RD:   state_nxt = S_DUMP_WAIT;
            S_DUMP_WAIT: state_nxt = S_DUMP_OUT;
            S_DUMP_OUT:  if (out_fire) state_nxt = k_last ? S_IDLE : S_DUMP_RD;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Debug-port and stream outputs are all registered; the BRAM sees a clean one-cycle write strobe.
    always_ff @(posedge CPU_CLK) begin
        if (!CPU_RST) begin
            sel_r            <= 1'b0;
            base_r           <= '0;
            len_r            <= '0;
            cycles_r         <= '0;
            k                <= '0;
            cnt              <= '0;
            core_rst         <= 1'b1;
            bus.done         <= 1'b0;
            bus.out_valid    <= 1'b0;
            bus.out_last     <= 1'b0;
            bus.out_data     <= '0;
            bus.dbg_data_a2  <= '0;
            bus.dbg_data_wd2 <= '0;
            bus.dbg_data_we2 <= '0;
            bus.dbg_inst_a2  <= '0;
            bus.dbg_inst_wd2 <= '0;
            bus.dbg_inst_we2 <= '0;
`ifdef LOAD_CHECKSUM_EN
            load_sum         <= '0;
`endif
        end else begin
            bus.done         <= 1'b0;
            bus.dbg_data_we2 <= '0;
            bus.dbg_inst_we2 <= '0;
            case (state)
                S_IDLE: if (bus.cmd_valid) begin
                    sel_r    <= bus.cmd_sel;
                    base_r   <= bus.cmd_base[AW-1:0];
                    len_r    <= len_c;
                    cycles_r <= bus.cmd_cycles;
                    k        <= '0;
                    cnt      <= '0;
                    case (bus.cmd_op)
                        OP_LOAD: begin
                            bus.dbg_data_a2 <= '0;
                            bus.dbg_inst_a2 <= '0;
                            if (len_c == '0) bus.done <= 1'b1;
                            else             core_rst <= 1'b1;
`ifdef LOAD_CHECKSUM_EN
                            load_sum <= '0;
`endif
                        end
                        OP_RUN: core_rst <= 1'b1;
                        OP_DUMP: begin
                            bus.dbg_data_a2 <= '0;
                            bus.dbg_inst_a2 <= '0;
                            if (len_c == '0)      bus.done        <= 1'b1;
                            else if (bus.cmd_sel) bus.dbg_inst_a2 <= byte_addr(bus.cmd_base[AW-1:0]);
                            else                  bus.dbg_data_a2 <= byte_addr(bus.cmd_base[AW-1:0]);
                        end
                        default: ;
                    endcase
                end
                S_LOAD: if (in_fire) begin
                    if (sel_r) begin
                        bus.dbg_inst_a2  <= byte_addr(idx_cur);
                        bus.dbg_inst_wd2 <= bus.in_data;
                        bus.dbg_inst_we2 <= 4'hF;
                    end else begin
                        bus.dbg_data_a2  <= byte_addr(idx_cur);
                        bus.dbg_data_wd2 <= bus.in_data;
                        bus.dbg_data_we2 <= 4'hF;
                    end
`ifdef LOAD_CHECKSUM_EN
                    load_sum <= load_sum + bus.in_data;
`endif
                    k <= k + 13'd1;
                    if (k_last) bus.done <= 1'b1;
                end
                S_RST_PULSE: begin
                    if (cnt == 32'(RST_CYCLES - 1)) begin
                        core_rst <= 1'b0;
                        cnt      <= cycles_r;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                // cnt holds the remaining run cycles; 0 and 1 both finish after one RUN cycle.
                S_RUN: begin
                    if (cnt <= 32'd1) bus.done <= 1'b1;
                    else              cnt      <= cnt - 32'd1;
                end
                S_DUMP_WAIT: begin
                    bus.out_data  <= sel_r ? bus.dbg_inst_rd2 : bus.dbg_data_rd2;
                    bus.out_valid <= 1'b1;
                    bus.out_last  <= k_last;
                end
                S_DUMP_OUT: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.out_last  <= 1'b0;
                    if (k_last) begin
                        bus.done <= 1'b1;
                    end else begin
                        k <= k + 13'd1;
                        if (sel_r) bus.dbg_inst_a2 <= byte_addr(idx_next);
                        else       bus.dbg_data_a2 <= byte_addr(idx_next);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_debug_sequencer.sv
// Directed bench for bram_debug_sequencer with behavioural 1-cycle-read BRAM models.
module tb_bram_debug_sequencer;
    logic CPU_CLK = 1'b0;
    logic CPU_RST = 1'b0;
    logic core_rst;
`ifdef LOAD_CHECKSUM_EN
    logic [31:0] load_sum;
`endif

    bram_debug_sequencer_if bus();

    bram_debug_sequencer #(.BRAMWORDS(4096), .RST_CYCLES(5)) dut (
        .CPU_CLK  (CPU_CLK),
        .CPU_RST  (CPU_RST),
        .bus      (bus),
        .core_rst (core_rst)
`ifdef LOAD_CHECKSUM_EN
        ,
        .load_sum (load_sum)
`endif
    );

    always #5 CPU_CLK = ~CPU_CLK;

    logic [31:0] dmem [4096];
    logic [31:0] imem [4096];
    logic [31:0] data_rd = '0, inst_rd = '0;
    int data_wr = 0, inst_wr = 0;
    int checks = 0, passes = 0, fails = 0;

    assign bus.dbg_data_rd2 = data_rd;
    assign bus.dbg_inst_rd2 = inst_rd;

    always @(posedge CPU_CLK) begin
        data_rd <= dmem[bus.dbg_data_a2[13:2]];
        inst_rd <= imem[bus.dbg_inst_a2[13:2]];
        if (bus.dbg_data_we2 == 4'hF) dmem[bus.dbg_data_a2[13:2]] = bus.dbg_data_wd2;
        if (bus.dbg_inst_we2 == 4'hF) imem[bus.dbg_inst_a2[13:2]] = bus.dbg_inst_wd2;
        if (bus.dbg_data_we2 != 4'h0) data_wr <= data_wr + 1;
        if (bus.dbg_inst_we2 != 4'h0) inst_wr <= inst_wr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic sel, input logic [11:0] base,
                            input logic [12:0] len, input logic [31:0] cyc);
        @(negedge CPU_CLK);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_sel = sel;
        bus.cmd_base = base; bus.cmd_len = len; bus.cmd_cycles = cyc;
        @(negedge CPU_CLK);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic load_check(input logic sel, input logic [11:0] base, input int n,
                              input logic [31:0] w [4], input logic [31:0] ea [4]);
        @(negedge CPU_CLK);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_sel = sel;
        bus.cmd_base = base; bus.cmd_len = 13'(n);
        bus.in_valid = 1'b1; bus.in_data = w[0];
        @(negedge CPU_CLK);
        bus.cmd_valid = 1'b0;
        chk("ld_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < n; i++) begin
            @(negedge CPU_CLK);
            chk("ld_we",     32'(sel ? bus.dbg_inst_we2 : bus.dbg_data_we2), 32'hF);
            chk("ld_a2",     sel ? bus.dbg_inst_a2 : bus.dbg_data_a2, ea[i]);
            chk("ld_wd",     sel ? bus.dbg_inst_wd2 : bus.dbg_data_wd2, w[i]);
            chk("ld_oth_we", 32'(sel ? bus.dbg_data_we2 : bus.dbg_inst_we2), 32'd0);
            chk("ld_core_rst", 32'(core_rst), 32'd1);
            chk("ld_done",   32'(bus.done), 32'(i == n - 1));
            if (i < n - 1) bus.in_data = w[i + 1];
            else           bus.in_valid = 1'b0;
        end
        @(negedge CPU_CLK);
        chk("ld_done_end", 32'(bus.done), 32'd0);
        chk("ld_we_end",   32'(sel ? bus.dbg_inst_we2 : bus.dbg_data_we2), 32'd0);
        chk("ld_in_rdy_end", 32'(bus.in_ready), 32'd0);
    endtask

    task automatic run_check(input logic [31:0] cyc, input int exp_lat);
        int hi, n, w0;
        w0 = data_wr + inst_wr;
        send_cmd(2'd1, 1'b0, 12'd0, 13'd0, cyc);
        hi = 0;
        while (core_rst === 1'b1 && hi < 20) begin hi++; @(negedge CPU_CLK); end
        chk("run_rst_hi", 32'(hi), 32'd5);
        n = 0;
        while (bus.done !== 1'b1 && n < 300) begin n++; @(negedge CPU_CLK); end
        chk("run_done_lat", 32'(n), 32'(exp_lat));
        @(negedge CPU_CLK);
        chk("run_done_pulse", 32'(bus.done), 32'd0);
        chk("run_core_low",   32'(core_rst), 32'd0);
        chk("run_idle",       32'(bus.cmd_ready), 32'd1);
        chk("run_no_write",   32'(data_wr + inst_wr - w0), 32'd0);
    endtask

    initial begin
        logic [31:0] w [4];
        logic [31:0] ea [4];
        logic [31:0] exp_d [3];
        int n, w0, j, prev;

        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_sel = 0; bus.cmd_base = 0;
        bus.cmd_len = 0; bus.cmd_cycles = 0; bus.in_valid = 0; bus.in_data = 0;
        bus.out_ready = 0;
        for (int i = 0; i < 4096; i++) begin
            dmem[i] = 32'hD000_0000 + 32'(i);
            imem[i] = 32'hE000_0000 + 32'(i);
        end

        repeat (3) @(negedge CPU_CLK);
        chk("rst_core_rst",  32'(core_rst), 32'd1);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_in_ready",  32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_last",  32'(bus.out_last), 32'd0);
        chk("rst_done",      32'(bus.done), 32'd0);
        chk("rst_data_a2",   bus.dbg_data_a2, 32'd0);
        chk("rst_data_we",   32'(bus.dbg_data_we2), 32'd0);
        chk("rst_inst_a2",   bus.dbg_inst_a2, 32'd0);
        chk("rst_inst_wd",   bus.dbg_inst_wd2, 32'd0);
        CPU_RST = 1'b1;

        // LOAD three instructions into InstRAM at word 0
        w  = '{32'h0000_0013, 32'h0010_0093, 32'h0020_8113, 32'h0};
        ea = '{32'h0, 32'h4, 32'h8, 32'h0};
        load_check(1'b1, 12'd0, 3, w, ea);
        chk("ld1_imem2", imem[2], 32'h0020_8113);
        chk("ld1_no_data_wr", 32'(data_wr), 32'd0);

        // LOAD wrapping past the top of DataRAM
        w  = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        ea = '{32'h3FF8, 32'h3FFC, 32'h0000, 32'h0004};
        load_check(1'b0, 12'd4094, 4, w, ea);
`ifdef LOAD_CHECKSUM_EN
        chk("ld2_sum", load_sum, 32'hAAAA_AAAA);
`endif
        chk("ld2_dmem4094", dmem[4094], 32'h1111_1111);
        chk("ld2_dmem1",    dmem[1],    32'h4444_4444);

        run_check(32'd100, 100);
        run_check(32'd0, 1);

        // DUMP DataRAM 0..2 with a stalling consumer
        exp_d = '{32'h3333_3333, 32'h4444_4444, 32'hD000_0002};
        w0 = data_wr + inst_wr;
        send_cmd(2'd2, 1'b0, 12'd0, 13'd3, 32'd0);
        chk("dmp_a2_0", bus.dbg_data_a2, 32'd0);
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (bus.out_valid !== 1'b1 && n < 10) begin n++; @(negedge CPU_CLK); end
            chk("dmp_valid", 32'(bus.out_valid), 32'd1);
            chk("dmp_data",  bus.out_data, exp_d[i]);
            chk("dmp_last",  32'(bus.out_last), 32'(i == 2));
            repeat (2) @(negedge CPU_CLK);
            chk("dmp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("dmp_hold_data",  bus.out_data, exp_d[i]);
            chk("dmp_hold_last",  32'(bus.out_last), 32'(i == 2));
            bus.out_ready = 1'b1;
            @(negedge CPU_CLK);
            bus.out_ready = 1'b0;
            chk("dmp_hs_valid", 32'(bus.out_valid), 32'd0);
            chk("dmp_done",     32'(bus.done), 32'(i == 2));
            if (i < 2) chk("dmp_next_a2", bus.dbg_data_a2, 32'(4 * (i + 1)));
        end
        chk("dmp_core_low", 32'(core_rst), 32'd0);
        chk("dmp_no_write", 32'(data_wr + inst_wr - w0), 32'd0);

        // DUMP InstRAM with out_ready tied high: one word every 3 cycles
        exp_d = '{32'h0000_0013, 32'h0010_0093, 32'h0020_8113};
        bus.out_ready = 1'b1;
        send_cmd(2'd2, 1'b1, 12'd0, 13'd3, 32'd0);
        chk("dmp2_unsel_a2", bus.dbg_data_a2, 32'd0);
        j = 0; prev = 0;
        for (int t = 0; t < 15; t++) begin
            if (bus.out_valid === 1'b1 && j < 3) begin
                chk("dmp2_data", bus.out_data, exp_d[j]);
                if (j > 0) chk("dmp2_gap", 32'(t - prev), 32'd3);
                prev = t;
                j++;
            end
            @(negedge CPU_CLK);
        end
        chk("dmp2_count", 32'(j), 32'd3);
        bus.out_ready = 1'b0;

        // Reserved op is ignored
        send_cmd(2'd3, 1'b0, 12'd0, 13'd1, 32'd0);
        chk("op3_done",  32'(bus.done), 32'd0);
        chk("op3_ready", 32'(bus.cmd_ready), 32'd1);

        // Zero-length LOAD and DUMP complete immediately
        w0 = data_wr + inst_wr;
        send_cmd(2'd0, 1'b0, 12'd5, 13'd0, 32'd0);
        chk("len0_ld_done",  32'(bus.done), 32'd1);
        chk("len0_ld_idle",  32'(bus.cmd_ready), 32'd1);
        send_cmd(2'd2, 1'b0, 12'd5, 13'd0, 32'd0);
        chk("len0_dmp_done", 32'(bus.done), 32'd1);
        chk("len0_dmp_ov",   32'(bus.out_valid), 32'd0);
        @(negedge CPU_CLK);
        chk("len0_no_write", 32'(data_wr + inst_wr - w0), 32'd0);

        // Reset after two LOAD words
        @(negedge CPU_CLK);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_sel = 1'b0;
        bus.cmd_base = 12'd16; bus.cmd_len = 13'd4;
        bus.in_valid = 1'b1; bus.in_data = 32'hA000_0000;
        @(negedge CPU_CLK);
        bus.cmd_valid = 1'b0;
        @(negedge CPU_CLK);
        bus.in_data = 32'hA000_0001;
        @(negedge CPU_CLK);
        CPU_RST = 1'b0; bus.in_valid = 1'b0;
        @(negedge CPU_CLK);
        chk("mrst_idle",     32'(bus.cmd_ready), 32'd1);
        chk("mrst_we",       32'(bus.dbg_data_we2), 32'd0);
        chk("mrst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("mrst_done",     32'(bus.done), 32'd0);
        CPU_RST = 1'b1;
        @(negedge CPU_CLK);
        chk("mrst_done2",  32'(bus.done), 32'd0);
        chk("mrst_word0",  dmem[16], 32'hA000_0000);
        chk("mrst_word1",  dmem[17], 32'hA000_0001);
        chk("mrst_word2",  dmem[18], 32'hD000_0012);

        // Oversized LOAD clamps to the BRAM size
        w0 = inst_wr;
        @(negedge CPU_CLK);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_sel = 1'b1;
        bus.cmd_base = 12'd100; bus.cmd_len = 13'd5000;
        bus.in_valid = 1'b1; bus.in_data = 32'h5A5A_0000;
        @(negedge CPU_CLK);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 6000) begin n++; @(negedge CPU_CLK); end
        bus.in_valid = 1'b0;
        chk("clamp_lat", 32'(n), 32'd4096);
        @(negedge CPU_CLK);
        chk("clamp_writes", 32'(inst_wr - w0), 32'd4096);
        chk("clamp_wrap",   imem[99], 32'h5A5A_0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
